// File: rtl/seq_addsub_32_bit.sv
// Multi-cycle adder/subtractor: one SLICE-wide ripple slice reused over WIDTH/SLICE cycles,
// low slice first, with valid/ready handshakes and carry/borrow/overflow/zero/neg flags.
module seq_addsub_32_bit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             neg
);
  localparam int N   = WIDTH / SLICE;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_eff_reg, acc_reg, s_reg;
  logic [IW-1:0]    index_reg;
  logic             carry_reg;
  logic             c_out_reg, borrow_reg, overflow_reg, zero_reg, neg_reg;
  logic             op_reg;
  logic             accept, last_slice;
  logic [SLICE-1:0] a_slice [N];
  logic [SLICE-1:0] b_slice [N];
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] s_full;

  assign accept     = in_valid && (state_reg == IDLE);
  assign last_slice = (index_reg == LAST);

  // s_full is the working result with the current slice merged in; only the
  // completed value is ever copied to the visible s register.
  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign a_slice[gi] = a_reg[gi*SLICE +: SLICE];
    assign b_slice[gi] = b_eff_reg[gi*SLICE +: SLICE];
    assign s_full[gi*SLICE +: SLICE] = (index_reg == IW'(gi)) ? slice_sum[SLICE-1:0]
                                                              : acc_reg[gi*SLICE +: SLICE];
  end

  assign slice_sum = {1'b0, a_slice[index_reg]} + {1'b0, b_slice[index_reg]}
                   + (SLICE+1)'(carry_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_eff_reg    <= '0;
      acc_reg      <= '0;
      s_reg        <= '0;
      index_reg    <= '0;
      carry_reg    <= 1'b0;
      op_reg       <= 1'b0;
      c_out_reg    <= 1'b0;
      borrow_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
      neg_reg      <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_eff_reg <= sub ? ~b : b;
      op_reg    <= sub;
      carry_reg <= sub;
      index_reg <= '0;
    end else if (state_reg == CALC) begin
      acc_reg   <= s_full;
      carry_reg <= slice_sum[SLICE];
      index_reg <= index_reg + IW'(1);
      if (last_slice) begin
        s_reg        <= s_full;
        c_out_reg    <= slice_sum[SLICE];
        borrow_reg   <= op_reg & ~slice_sum[SLICE];
        overflow_reg <= (a_reg[MSB] == b_eff_reg[MSB]) && (s_full[MSB] != a_reg[MSB]);
        zero_reg     <= ~|s_full;
        neg_reg      <= s_full[MSB];
      end
    end
  end

  assign s        = s_reg;
  assign c_out    = c_out_reg;
  assign borrow   = borrow_reg;
  assign overflow = overflow_reg;
  assign zero     = zero_reg;
  assign neg      = neg_reg;

endmodule

// File: tb/tb_seq_addsub_32_bit.sv
// Bench for seq_addsub_32_bit: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed literal results.
module tb_seq_addsub_32_bit;
  localparam int N = 2;

  logic        clk, rst_n, in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a, b, s;
  logic        c_out, borrow, overflow, zero, neg;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          m_busy = 0;
  int          m_age = 0;
  bit          was_busy, exp_out_valid;
  logic [31:0] m_s, m_beff;
  logic [32:0] m_sum;
  logic [4:0]  m_flags;  // {c_out, borrow, overflow, zero, neg}

  seq_addsub_32_bit #(.WIDTH(32), .SLICE(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .borrow(borrow), .overflow(overflow), .zero(zero), .neg(neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_s", {32'b0, s}, 64'd0);
      chk("rst_flags", {59'b0, c_out, borrow, overflow, zero, neg}, 64'd0);
      m_busy = 0;
    end else begin
      was_busy = m_busy;
      if (m_busy) m_age++;
      exp_out_valid = m_busy && (m_age >= N + 1);
      chk("in_ready", {63'b0, in_ready}, {63'b0, !m_busy});
      chk("out_valid", {63'b0, out_valid}, {63'b0, exp_out_valid});
      if (exp_out_valid) begin
        chk("model_s", {32'b0, s}, {32'b0, m_s});
        chk("model_flags", {59'b0, c_out, borrow, overflow, zero, neg}, {59'b0, m_flags});
        if (out_ready) m_busy = 0;
      end
      if (!was_busy && in_valid) begin
        m_beff  = sub ? ~b : b;
        m_sum   = {1'b0, a} + {1'b0, m_beff} + {32'b0, sub};
        m_s     = m_sum[31:0];
        m_flags = {m_sum[32], sub & ~m_sum[32],
                   (a[31] == m_beff[31]) && (m_s[31] != a[31]),
                   m_s == 32'd0, m_s[31]};
        m_busy  = 1;
        m_age   = 0;
      end
    end
  end

  task automatic wait_result(input string name, input logic [31:0] es, input logic [4:0] ef);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) begin
      chk({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({name, "_s"}, {32'b0, s}, {32'b0, es});
      chk({name, "_flags"}, {59'b0, c_out, borrow, overflow, zero, neg}, {59'b0, ef});
    end
    $display("op %s: s=%h c_out=%b borrow=%b overflow=%b zero=%b neg=%b",
             name, s, c_out, borrow, overflow, zero, neg);
  endtask

  // Drive one op, then scramble the inputs to show they are not re-sampled.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tsub,
                        input logic [31:0] es, input logic [4:0] ef, input string name);
    @(posedge clk); #1;
    a = ta; b = tb_v; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ta; sub = ~tsub;
    wait_result(name, es, ef);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(32'd5,        32'd3,        1'b1, 32'h0000_0002, 5'b10000, "sub_5_3");
    run_op(32'd0,        32'd1,        1'b1, 32'hFFFF_FFFF, 5'b01001, "sub_0_1");
    run_op(32'h8000_0000, 32'd1,       1'b1, 32'h7FFF_FFFF, 5'b10100, "sub_min_1");
    run_op(32'h0000_FFFF, 32'd1,       1'b0, 32'h0001_0000, 5'b00000, "add_slice_carry");
    run_op(32'hFFFF_FFFF, 32'd1,       1'b0, 32'h0000_0000, 5'b10010, "add_wrap");
    run_op(32'h1234_5678, 32'd0,       1'b1, 32'h1234_5678, 5'b10000, "sub_b_zero");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 5'b10110, "add_neg_ovf");

    // backpressure: result held for 5 cycles while a new op is offered
    @(posedge clk); #1 out_ready = 1'b0;
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 5'b00101, "add_pos_ovf_stall");
    @(posedge clk); #1;
    a = 32'h0001_0000; b = 32'd1; sub = 1'b1; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
    wait_result("sub_slice_borrow", 32'h0000_FFFF, 5'b10000);

    // abort in CALC
    @(posedge clk); #1;
    a = 32'd7; b = 32'd9; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {63'b0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'b0, in_ready}, 64'd1);
    chk("abort_s", {32'b0, s}, 64'd0);
    $display("op abort: out_valid=%b in_ready=%b s=%h", out_valid, in_ready, s);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(32'd9, 32'd7, 1'b1, 32'h0000_0002, 5'b10000, "sub_9_7_after_rst");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
